// File: rtl/sram_byte_loader.sv
// ---------------------------------------------------------------------------
// sram_byte_loader
//
// Upstream feeder for the SRAM initialisation path. Takes a byte stream over
// a valid/ready handshake, packs every four bytes into a little-endian word
// and presents it on init_enable/init_data/init_addr for WR_CYCLES cycles.
// mode_set is held low (write mode) for the whole load. A one-cycle done
// pulse then tells the rest of the design it may switch the SRAM back to
// read mode.
//
// Ports
//   CLK          system clock, rising edge
//   RSTn         asynchronous active-low reset
//   start        one-cycle load request, honoured only while idle
//   abort        synchronous cancel, overrides everything else
//   word_count   number of words to load, captured with an accepted start
//   byte_valid   upstream byte present
//   byte_data    upstream byte
//   byte_ready   loader takes a byte this cycle
//   init_enable  write strobe toward the SRAM init stage
//   init_data    packed word, stable while init_enable is high
//   init_addr    word address being written
//   mode_set     1 = SRAM read mode, 0 = write mode
//   busy         a load is in progress
//   done         one-cycle pulse after the final word's write window
// ---------------------------------------------------------------------------
module sram_byte_loader #(
    parameter int ADDRW     = 19,
    parameter int DATAW     = 32,
    parameter int WR_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic             abort,
    input  logic [ADDRW:0]   word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             init_enable,
    output logic [DATAW-1:0] init_data,
    output logic [ADDRW-1:0] init_addr,
    output logic             mode_set,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    // Within S_WRITE the hold counter runs 0..WR_CYCLES-1 with the strobe
    // high, then takes the value WR_CYCLES for the single turnaround cycle
    // that precedes collecting the next word.
    localparam logic [3:0]       HOLD_LAST = 4'(WR_CYCLES - 1);
    localparam logic [3:0]       HOLD_TURN = 4'(WR_CYCLES);
    localparam logic [ADDRW:0]   CNT_ONE   = (ADDRW+1)'(1);
    localparam logic [ADDRW-1:0] ADDR_ONE  = ADDRW'(1);

    state_t           state;
    logic [1:0]       byte_idx;
    logic [3:0]       hold_cnt;
    logic [ADDRW:0]   word_cnt;
    logic [ADDRW:0]   word_total;
    logic [ADDRW:0]   word_cnt_next;

    // Words written once the current window closes; compared against the
    // latched total to spot the final word. Widths are ADDRW+1 so a full
    // 2^ADDRW load is representable and init_addr never has to wrap past
    // the last address.
    always_comb begin
        word_cnt_next = word_cnt + CNT_ONE;
    end

    // Single state machine; every output is a register updated here.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= S_IDLE;
            byte_ready  <= 1'b0;
            init_enable <= 1'b0;
            init_data   <= '0;
            init_addr   <= '0;
            mode_set    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_idx    <= 2'd0;
            hold_cnt    <= 4'd0;
            word_cnt    <= '0;
            word_total  <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Partial word is simply dropped; no done pulse.
                state       <= S_IDLE;
                byte_ready  <= 1'b0;
                init_enable <= 1'b0;
                mode_set    <= 1'b1;
                busy        <= 1'b0;
                byte_idx    <= 2'd0;
                hold_cnt    <= 4'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (word_count != '0) begin
                                word_total <= word_count;
                                word_cnt   <= '0;
                                init_addr  <= '0;
                                byte_idx   <= 2'd0;
                                hold_cnt   <= 4'd0;
                                mode_set   <= 1'b0;
                                busy       <= 1'b1;
                                byte_ready <= 1'b1;
                                state      <= S_COLLECT;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end

                    S_COLLECT: begin
                        if (byte_valid && byte_ready) begin
                            init_data[{byte_idx, 3'b000} +: 8] <= byte_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                byte_ready  <= 1'b0;
                                init_enable <= 1'b1;
                                hold_cnt    <= 4'd0;
                                state       <= S_WRITE;
                            end
                        end
                    end

                    S_WRITE: begin
                        if (hold_cnt == HOLD_LAST) begin
                            init_enable <= 1'b0;
                            word_cnt    <= word_cnt_next;
                            if (word_cnt_next == word_total) begin
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                mode_set <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                init_addr <= init_addr + ADDR_ONE;
                                hold_cnt  <= hold_cnt + 4'd1;
                            end
                        end else if (hold_cnt == HOLD_TURN) begin
                            byte_ready <= 1'b1;
                            byte_idx   <= 2'd0;
                            hold_cnt   <= 4'd0;
                            state      <= S_COLLECT;
                        end else begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_byte_loader.sv
// ---------------------------------------------------------------------------
// tb_sram_byte_loader
//
// Directed bench for sram_byte_loader with WR_CYCLES=2. Inputs are driven
// 1 ns after each rising edge and outputs sampled at the same point, so each
// sample shows the registers updated by the edge just passed. A small
// negedge monitor records every write window (data, address, strobe length)
// and done pulses for the end-of-sequence checks.
// ---------------------------------------------------------------------------
module tb_sram_byte_loader;

    localparam int ADDRW = 19;
    localparam int DATAW = 32;

    logic             CLK;
    logic             RSTn;
    logic             start;
    logic             abort;
    logic [ADDRW:0]   word_count;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             init_enable;
    logic [DATAW-1:0] init_data;
    logic [ADDRW-1:0] init_addr;
    logic             mode_set;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;

    logic [31:0] wr_data [0:15];
    logic [31:0] wr_addr [0:15];
    int          wr_count;
    int          en_cycles;
    int          done_count;
    int          ready_viol;
    int          mode_viol;
    logic        prev_en;

    sram_byte_loader #(
        .ADDRW(ADDRW),
        .DATAW(DATAW),
        .WR_CYCLES(2)
    ) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .start(start),
        .abort(abort),
        .word_count(word_count),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .init_enable(init_enable),
        .init_data(init_data),
        .init_addr(init_addr),
        .mode_set(mode_set),
        .busy(busy),
        .done(done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: captures each write window on its first strobe cycle.
    always @(negedge CLK) begin
        if (init_enable && !prev_en && wr_count < 16) begin
            wr_data[wr_count] = init_data;
            wr_addr[wr_count] = 32'(init_addr);
            wr_count++;
        end
        if (init_enable) en_cycles++;
        if (done) done_count++;
        if (init_enable && byte_ready) ready_viol++;
        if (busy && mode_set) mode_viol++;
        prev_en = init_enable;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for byte_ready, then presents one byte for one edge.
    task automatic applyStimulus(input logic [7:0] b);
        for (int i = 0; i < 50 && !byte_ready; i++) tick();
        if (!byte_ready) checkOutput("ready_timeout", 32'(byte_ready), 32'd1);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        for (int i = 0; i < 100 && !done; i++) tick();
        checkOutput(tag, 32'(done), 32'd1);
        tick();
    endtask

    int base_wr;
    int base_done;
    int base_en;

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_count    = 0;
        en_cycles   = 0;
        done_count  = 0;
        ready_viol  = 0;
        mode_viol   = 0;
        prev_en     = 1'b0;
        RSTn        = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        word_count  = '0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ready",  32'(byte_ready),  32'd0);
        checkOutput("rst_enable", 32'(init_enable), 32'd0);
        checkOutput("rst_data",   init_data,        32'h0);
        checkOutput("rst_addr",   32'(init_addr),   32'd0);
        checkOutput("rst_mode",   32'(mode_set),    32'd1);
        checkOutput("rst_busy",   32'(busy),        32'd0);
        checkOutput("rst_done",   32'(done),        32'd0);
        RSTn = 1'b1;
        tick();

        // Two-word load, back-to-back bytes, cycle-exact
        base_en    = en_cycles;
        start      = 1'b1;
        word_count = 20'd2;
        tick();
        start = 1'b0;
        checkOutput("t1_ready", 32'(byte_ready), 32'd1);
        checkOutput("t1_mode",  32'(mode_set),   32'd0);
        checkOutput("t1_busy",  32'(busy),       32'd1);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        checkOutput("t1_w0_en",    32'(init_enable), 32'd1);
        checkOutput("t1_w0_data",  init_data,        32'h44332211);
        checkOutput("t1_w0_addr",  32'(init_addr),   32'd0);
        checkOutput("t1_w0_ready", 32'(byte_ready),  32'd0);
        tick();
        checkOutput("t1_w0_en2",   32'(init_enable), 32'd1);
        checkOutput("t1_w0_data2", init_data,        32'h44332211);
        tick();
        checkOutput("t1_turn_en",    32'(init_enable), 32'd0);
        checkOutput("t1_turn_addr",  32'(init_addr),   32'd1);
        checkOutput("t1_turn_ready", 32'(byte_ready),  32'd0);
        tick();
        checkOutput("t1_w1_ready", 32'(byte_ready), 32'd1);
        applyStimulus(8'h55);
        applyStimulus(8'h66);
        applyStimulus(8'h77);
        applyStimulus(8'h88);
        checkOutput("t1_w1_en",   32'(init_enable), 32'd1);
        checkOutput("t1_w1_data", init_data,        32'h88776655);
        checkOutput("t1_w1_addr", 32'(init_addr),   32'd1);
        tick();
        checkOutput("t1_w1_en2", 32'(init_enable), 32'd1);
        tick();
        checkOutput("t1_done",      32'(done),        32'd1);
        checkOutput("t1_done_en",   32'(init_enable), 32'd0);
        checkOutput("t1_done_busy", 32'(busy),        32'd0);
        checkOutput("t1_done_mode", 32'(mode_set),    32'd1);
        tick();
        checkOutput("t1_done_clr", 32'(done), 32'd0);
        checkOutput("t1_en_cycles", 32'(en_cycles - base_en), 32'd4);

        // Same load with byte_valid toggling
        base_wr   = wr_count;
        base_done = done_count;
        start      = 1'b1;
        word_count = 20'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            byte_valid = 1'b0;
            tick();
            applyStimulus(8'(8'h11 * (k + 1)));
        end
        waitDone("t2_done");
        checkOutput("t2_writes", 32'(wr_count - base_wr),  32'd2);
        checkOutput("t2_d0",     wr_data[base_wr],         32'h44332211);
        checkOutput("t2_a0",     wr_addr[base_wr],         32'd0);
        checkOutput("t2_d1",     wr_data[base_wr + 1],     32'h88776655);
        checkOutput("t2_a1",     wr_addr[base_wr + 1],     32'd1);
        checkOutput("t2_dones",  32'(done_count - base_done), 32'd1);

        // Zero-length load
        base_wr    = wr_count;
        start      = 1'b1;
        word_count = 20'd0;
        tick();
        start = 1'b0;
        checkOutput("t3_done", 32'(done),     32'd1);
        checkOutput("t3_mode", 32'(mode_set), 32'd1);
        checkOutput("t3_busy", 32'(busy),     32'd0);
        tick();
        checkOutput("t3_done_clr", 32'(done), 32'd0);
        tick();
        checkOutput("t3_no_write", 32'(wr_count - base_wr), 32'd0);

        // Abort after two bytes, then a fresh one-word load
        base_wr    = wr_count;
        base_done  = done_count;
        start      = 1'b1;
        word_count = 20'd2;
        tick();
        start = 1'b0;
        applyStimulus(8'hA1);
        applyStimulus(8'hA2);
        abort      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA3;
        tick();
        abort      = 1'b0;
        byte_valid = 1'b0;
        checkOutput("t4_busy",  32'(busy),        32'd0);
        checkOutput("t4_mode",  32'(mode_set),    32'd1);
        checkOutput("t4_ready", 32'(byte_ready),  32'd0);
        checkOutput("t4_en",    32'(init_enable), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("t4_no_write", 32'(wr_count - base_wr),     32'd0);
        checkOutput("t4_no_done",  32'(done_count - base_done), 32'd0);
        start      = 1'b1;
        word_count = 20'd1;
        tick();
        start = 1'b0;
        applyStimulus(8'hDE);
        applyStimulus(8'hAD);
        applyStimulus(8'hBE);
        applyStimulus(8'hEF);
        waitDone("t4_done");
        checkOutput("t4_writes", 32'(wr_count - base_wr), 32'd1);
        checkOutput("t4_d0",     wr_data[base_wr],        32'hEFBEADDE);
        checkOutput("t4_a0",     wr_addr[base_wr],        32'd0);

        // start during a load is ignored
        base_wr    = wr_count;
        base_done  = done_count;
        start      = 1'b1;
        word_count = 20'd2;
        tick();
        start = 1'b0;
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        start      = 1'b1;
        word_count = 20'd5;
        applyStimulus(8'h03);
        start = 1'b0;
        applyStimulus(8'h04);
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        tick();
        applyStimulus(8'h05);
        applyStimulus(8'h06);
        applyStimulus(8'h07);
        applyStimulus(8'h08);
        waitDone("t5_done");
        checkOutput("t5_writes", 32'(wr_count - base_wr),     32'd2);
        checkOutput("t5_d0",     wr_data[base_wr],            32'h04030201);
        checkOutput("t5_d1",     wr_data[base_wr + 1],        32'h08070605);
        checkOutput("t5_a1",     wr_addr[base_wr + 1],        32'd1);
        checkOutput("t5_dones",  32'(done_count - base_done), 32'd1);
        checkOutput("t5_idle",   32'(busy),                   32'd0);

        // Reset pulled during a write window
        start      = 1'b1;
        word_count = 20'd3;
        tick();
        start = 1'b0;
        applyStimulus(8'hC1);
        applyStimulus(8'hC2);
        applyStimulus(8'hC3);
        applyStimulus(8'hC4);
        checkOutput("t6_pre_en", 32'(init_enable), 32'd1);
        #2;
        RSTn = 1'b0;
        #1;
        checkOutput("t6_en",    32'(init_enable), 32'd0);
        checkOutput("t6_mode",  32'(mode_set),    32'd1);
        checkOutput("t6_addr",  32'(init_addr),   32'd0);
        checkOutput("t6_busy",  32'(busy),        32'd0);
        checkOutput("t6_data",  init_data,        32'h0);
        tick();
        RSTn = 1'b1;
        tick();
        base_wr    = wr_count;
        start      = 1'b1;
        word_count = 20'd1;
        tick();
        start = 1'b0;
        applyStimulus(8'h5A);
        applyStimulus(8'h6B);
        applyStimulus(8'h7C);
        applyStimulus(8'h8D);
        waitDone("t6_done");
        checkOutput("t6_d0", wr_data[base_wr], 32'h8D7C6B5A);
        checkOutput("t6_a0", wr_addr[base_wr], 32'd0);

        // Whole-run invariants
        checkOutput("ready_in_write", 32'(ready_viol), 32'd0);
        checkOutput("mode_while_busy", 32'(mode_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
